// File: rtl/preg_free_list.sv
// Physical register free list for a 2-wide rename/retire pipeline.
// A circular buffer holds free PReg numbers. Rename takes up to two entries from
// the head, and retire returns up to two entries at the tail. Allocation is
// all-or-nothing. A release that does not fit is dropped and sets a sticky flag.
module preg_free_list #(
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned P_REG_W   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_alloc_en     [0:1],
    input  logic               i_release_en   [0:1],
    input  logic [P_REG_W-1:0] i_release_preg [0:1],
    output logic [P_REG_W-1:0] o_free_pregs   [0:1],
    output logic               o_free_valid   [0:1],
    output logic               o_stall,
    output logic [P_REG_W:0]   o_count,
    output logic               o_overflow
);

    localparam int unsigned      CNT_W     = P_REG_W + 1;
    localparam int unsigned      INIT_FREE = NUM_PREGS - NUM_AREGS;
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(NUM_PREGS);

    // Storage and pointers
    logic [P_REG_W-1:0] buf_q [NUM_PREGS];
    logic [P_REG_W-1:0] buf_d [NUM_PREGS];
    logic [P_REG_W-1:0] head_q, head_d;
    logic [P_REG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    // Per-cycle bookkeeping
    logic [CNT_W-1:0]   alloc_req;
    logic               alloc_gnt;
    logic [CNT_W-1:0]   alloc_num;
    logic [CNT_W-1:0]   count_post;
    logic [CNT_W-1:0]   space;
    logic               rel_ok0, rel_ok1;
    logic               acc0, acc1;
    logic [CNT_W-1:0]   rel_num;
    logic [P_REG_W-1:0] head_p1;
    logic [P_REG_W-1:0] wr_idx1;

    // Candidate outputs come straight from registered state. A release written
    // this cycle lands in buf_q only at the closing edge, so it shows up next cycle.
    assign head_p1         = head_q + P_REG_W'(1);
    assign o_free_pregs[0] = buf_q[head_q];
    assign o_free_pregs[1] = buf_q[head_p1];
    assign o_free_valid[0] = (count_q >= CNT_W'(1));
    assign o_free_valid[1] = (count_q >= CNT_W'(2));
    assign o_stall         = (count_q <  CNT_W'(2));
    assign o_count         = count_q;
    assign o_overflow      = overflow_q;

    // Allocation grant: all requested entries must be available, otherwise none.
    always_comb begin
        alloc_req  = CNT_W'(i_alloc_en[0]) + CNT_W'(i_alloc_en[1]);
        alloc_gnt  = (count_q >= alloc_req);
        alloc_num  = alloc_gnt ? alloc_req : '0;
        count_post = count_q - alloc_num;
    end

    // Release acceptance: PReg 0 is never freed. Overflow is checked against the
    // count left after this cycle's allocation. Slot 1 is dropped before slot 0.
    always_comb begin
        space   = CAP - count_post;
        rel_ok0 = i_release_en[0] && (i_release_preg[0] != '0);
        rel_ok1 = i_release_en[1] && (i_release_preg[1] != '0);
        acc0    = rel_ok0 && (space >= CNT_W'(1));
        acc1    = rel_ok1 && (space >= (CNT_W'(1) + CNT_W'(acc0)));
        rel_num = CNT_W'(acc0) + CNT_W'(acc1);
        wr_idx1 = tail_q + P_REG_W'(acc0);
    end

    // Next state for pointers, count, overflow flag and buffer contents.
    always_comb begin
        buf_d      = buf_q;
        head_d     = head_q + P_REG_W'(alloc_num);
        tail_d     = tail_q + P_REG_W'(rel_num);
        count_d    = count_post + rel_num;
        overflow_d = overflow_q | (rel_ok0 & ~acc0) | (rel_ok1 & ~acc1);
        if (acc0) begin
            buf_d[tail_q] = i_release_preg[0];
        end
        if (acc1) begin
            buf_d[wr_idx1] = i_release_preg[1];
        end
    end

    // Pointer, count and flag registers. Reset loads the post-boot free set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q     <= '0;
            tail_q     <= P_REG_W'(INIT_FREE);
            count_q    <= CNT_W'(INIT_FREE);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer registers. Entries beyond the initial free set start at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                buf_q[i] <= (i < INIT_FREE) ? P_REG_W'(NUM_AREGS + i) : '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list. Stimulus pushes the expected state after
// each clock edge, and a monitor pops and compares it just after that edge.
module tb_preg_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_en     [0:1];
    logic       release_en   [0:1];
    logic [5:0] release_preg [0:1];
    logic [5:0] free_pregs   [0:1];
    logic       free_valid   [0:1];
    logic       stall;
    logic [6:0] count;
    logic       overflow;

    preg_free_list #(.NUM_PREGS(64), .NUM_AREGS(32), .P_REG_W(6)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_alloc_en     (alloc_en),
        .i_release_en   (release_en),
        .i_release_preg (release_preg),
        .o_free_pregs   (free_pregs),
        .o_free_valid   (free_valid),
        .o_stall        (stall),
        .o_count        (count),
        .o_overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    p0;
        int    p1;
        int    cnt;
        int    ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mq[$];
    int   fl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Valid and stall follow from the expected count. Candidates are compared only when valid.
    task automatic chk_state(input exp_t e);
        chk({e.name, ".count"}, int'(count), e.cnt);
        chk({e.name, ".valid0"}, int'(free_valid[0]), (e.cnt >= 1) ? 1 : 0);
        chk({e.name, ".valid1"}, int'(free_valid[1]), (e.cnt >= 2) ? 1 : 0);
        chk({e.name, ".stall"}, int'(stall), (e.cnt < 2) ? 1 : 0);
        chk({e.name, ".overflow"}, int'(overflow), e.ovf);
        if (e.cnt >= 1) chk({e.name, ".preg0"}, int'(free_pregs[0]), e.p0);
        if (e.cnt >= 2) chk({e.name, ".preg1"}, int'(free_pregs[1]), e.p1);
    endtask

    function automatic exp_t mk(input string name, input int p0, input int p1,
                                input int cnt, input int ovf);
        exp_t e;
        e.name = name; e.p0 = p0; e.p1 = p1; e.cnt = cnt; e.ovf = ovf;
        return e;
    endfunction

    // Monitor: the state after each edge is checked against the oldest pending expectation
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk_state(mon_e);
        end
    end

    task automatic drive(input logic a0, input logic a1, input logic r0, input logic r1,
                         input int rp0, input int rp1);
        alloc_en[0]     = a0;
        alloc_en[1]     = a1;
        release_en[0]   = r0;
        release_en[1]   = r1;
        release_preg[0] = 6'(rp0);
        release_preg[1] = 6'(rp1);
    endtask

    task automatic step(input string name, input logic a0, input logic a1,
                        input logic r0, input logic r1, input int rp0, input int rp1,
                        input int ep0, input int ep1, input int ecnt, input int eovf);
        @(negedge clk);
        drive(a0, a1, r0, r1, rp0, rp1);
        sb.push_back(mk(name, ep0, ep1, ecnt, eovf));
        @(posedge clk);
    endtask

    // Reset is raised between clock edges and checked before any edge arrives.
    task automatic do_reset(input string name);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_state(mk(name, 32, 33, 32, 0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g0, g1, pr0, pr1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_state(mk("reset", 32, 33, 32, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back dual allocation
        step("alloc_a", 1, 1, 0, 0, 0, 0, 34, 35, 30, 0);
        step("alloc_b", 1, 1, 0, 0, 0, 0, 36, 37, 28, 0);
        step("alloc_c", 1, 1, 0, 0, 0, 0, 38, 39, 26, 0);

        // Drain to a single entry, then check the all-or-nothing grant
        for (int i = 0; i < 12; i++)
            step("drain", 1, 1, 0, 0, 0, 0, 40 + 2 * i, 41 + 2 * i, 24 - 2 * i, 0);
        step("cnt1", 1, 0, 0, 0, 0, 0, 63, 0, 1, 0);
        step("no_grant", 1, 1, 0, 0, 0, 0, 63, 0, 1, 0);
        step("cnt0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Release into an empty list with an ungrantable same-cycle alloc
        @(negedge clk);
        drive(1, 1, 1, 1, 5, 9);
        sb.push_back(mk("rel_empty", 5, 9, 2, 0));
        #1;
        chk("rel_hidden.valid0", int'(free_valid[0]), 0);
        chk("rel_hidden.count", int'(count), 0);
        @(posedge clk);
        step("rel_hold", 0, 0, 0, 0, 0, 0, 5, 9, 2, 0);

        // Alloc together with a release of 40 and PReg 0. 40 is reached after draining.
        do_reset("reset2");
        step("alloc_rel", 1, 1, 1, 1, 40, 0, 34, 35, 31, 0);
        for (int i = 0; i < 14; i++)
            step("drain2", 1, 1, 0, 0, 0, 0, 36 + 2 * i, 37 + 2 * i, 29 - 2 * i, 0);
        step("see40", 1, 1, 0, 0, 0, 0, 40, 0, 1, 0);

        // Sustained traffic: both pointers wrap many times and FIFO order holds
        do_reset("reset3");
        mq.delete();
        for (int i = 32; i < 64; i++) mq.push_back(i);
        pr0 = 0; pr1 = 0;
        for (int i = 0; i < 100; i++) begin
            g0 = mq.pop_front();
            g1 = mq.pop_front();
            if (i > 0) begin
                mq.push_back(pr0);
                mq.push_back(pr1);
            end
            step("wrap", 1, 1, i > 0, i > 0, pr0, pr1, mq[0], mq[1], mq.size(), 0);
            pr0 = g0; pr1 = g1;
        end

        // Fill to capacity, then check overflow drop order and the sticky flag
        do_reset("reset4");
        for (int i = 0; i < 15; i++)
            step("fill", 0, 0, 1, 1, 2 * i + 1, 2 * i + 2, 32, 33, 34 + 2 * i, 0);
        step("fill63", 0, 0, 1, 1, 31, 0, 32, 33, 63, 0);
        step("ovf_part", 0, 0, 1, 1, 7, 8, 32, 33, 64, 1);
        step("ovf_full", 0, 0, 1, 1, 7, 8, 32, 33, 64, 1);
        step("ovf_sticky", 0, 0, 0, 0, 0, 0, 32, 33, 64, 1);
        step("ovf_postalloc", 1, 0, 1, 1, 9, 10, 33, 34, 64, 1);

        // Drain the full list. Expected contents were worked out by hand.
        fl.delete();
        for (int v = 33; v < 64; v++) fl.push_back(v);
        for (int v = 1; v < 31; v++) fl.push_back(v);
        fl.push_back(31); fl.push_back(7); fl.push_back(9);
        for (int i = 0; i < 31; i++)
            step("drain_full", 1, 1, 0, 0, 0, 0, fl[2 * i + 2], fl[2 * i + 3], 62 - 2 * i, 1);

        // Async reset during active traffic: no partial update survives
        @(negedge clk);
        drive(1, 1, 1, 1, 11, 12);
        #2 rst = 1'b1;
        #1 chk_state(mk("async_rst", 32, 33, 32, 0));
        @(posedge clk);
        #1 chk_state(mk("rst_held", 32, 33, 32, 0));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step("post_rst", 0, 0, 0, 0, 0, 0, 32, 33, 32, 0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
